dmem_arbiter: RTL and testbench

//  Shares the single-port synchronous data RAM between two requesters: m0 (CPU data port) and m1 (loader/DMA).
//  One transfer is issued per cycle. Arbitration is round-robin, with an optional lock for read-modify-write pairs.

---
 rtl/riscv_soc_pkg.sv | 14 +
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_soc_pkg.sv
// Shared SoC types: data-RAM arbiter FSM encoding and requester IDs.
// Imported by the data-memory arbiter.
package riscv_soc_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic M0_ID = 1'b0;
    localparam logic M1_ID = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data RAM: round-robin or
// fixed m0 priority, optional lock for RMW pairs, read-data routing.
module dmem_arbiter
    import riscv_soc_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int M0_PRIO = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    state_q, state_d;
    logic          last_q, last_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_id_q, rd_id_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          g0, g1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ARB;
            last_q    <= M1_ID;
            rd_pend_q <= 1'b0;
            rd_id_q   <= M0_ID;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // Grant decision; gated by rstn so an asserted reset kills grants at once
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        case (state_q)
            ARB: begin
                if (m0_req && m1_req) begin
                    if (M0_PRIO != 0 || last_q == M1_ID) g0 = 1'b1;
                    else                                 g1 = 1'b1;
                end else begin
                    g0 = m0_req;
                    g1 = m1_req;
                end
            end
            LOCK0:   g0 = m0_req;
            LOCK1:   g1 = m1_req;
            default: ;
        endcase
        m0_gnt = g0 & rstn;
        m1_gnt = g1 & rstn;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (m0_gnt) begin
            state_d = m0_lock ? LOCK0 : ARB;
            last_d  = M0_ID;
        end else if (m1_gnt) begin
            state_d = m1_lock ? LOCK1 : ARB;
            last_d  = M1_ID;
        end
    end

    always_comb begin
        rd_pend_d = (m0_gnt & ~m0_wr) | (m1_gnt & ~m1_wr);
        rd_id_d   = m1_gnt ? M1_ID : M0_ID;
    end

    // Read return: route RAM data to the issuer, others hold last value
    always_comb begin
        m0_rvalid = rd_pend_q && (rd_id_q == M0_ID);
        m1_rvalid = rd_pend_q && (rd_id_q == M1_ID);
        rdata0_d  = m0_rvalid ? mem_rdata : rdata0_q;
        rdata1_d  = m1_rvalid ? mem_rdata : rdata1_q;
        m0_rdata  = rdata0_d;
        m1_rdata  = rdata1_d;
    end

    always_comb begin
        mem_en    = m0_gnt | m1_gnt;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_wr    = m0_wr;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_wr    = m1_wr;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: scenario tasks plus a read-data
// scoreboard fed at grant time and drained on rvalid.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_req, m0_wr, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_wr, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        mem_en, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        p0_req, p1_req;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p_en, p_wr;
    logic [31:0] p_addr, p_wdata;
    logic [31:0] p_rdata_in = 32'h0;

    int pass = 0;
    int total = 0;

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];

    logic [31:0] ram [0:255];
    logic [255:0] ram_wr = '0;
    logic [31:0] ref_mem [0:255];
    logic [255:0] ref_wr = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .M0_PRIO(0)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.AW(32), .DW(32), .M0_PRIO(1)) dut_p (
        .clk(clk), .rstn(rstn),
        .m0_req(p0_req), .m0_wr(1'b1), .m0_lock(1'b0),
        .m0_addr(32'h100), .m0_wdata(32'h1),
        .m0_gnt(p0_gnt), .m0_rvalid(p0_rvalid), .m0_rdata(p0_rdata),
        .m1_req(p1_req), .m1_wr(1'b1), .m1_lock(1'b0),
        .m1_addr(32'h200), .m1_wdata(32'h2),
        .m1_gnt(p1_gnt), .m1_rvalid(p1_rvalid), .m1_rdata(p1_rdata),
        .mem_en(p_en), .mem_wr(p_wr), .mem_addr(p_addr),
        .mem_wdata(p_wdata), .mem_rdata(p_rdata_in)
    );

    function automatic logic [31:0] init_val(input logic [7:0] i);
        if (i == 8'd2) return 32'h0000_0011;
        if (i == 8'd3) return 32'h0000_0022;
        return 32'hC0DE_0000 | {24'h0, i};
    endfunction

    function automatic logic [31:0] ref_val(input logic [31:0] a);
        if (ref_wr[a[9:2]]) return ref_mem[a[9:2]];
        return init_val(a[9:2]);
    endfunction

    // RAM model: 1-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) begin
                ram[mem_addr[9:2]]    <= mem_wdata;
                ram_wr[mem_addr[9:2]] <= 1'b1;
            end else begin
                mem_rdata <= ram_wr[mem_addr[9:2]] ? ram[mem_addr[9:2]]
                                                   : init_val(mem_addr[9:2]);
            end
        end
    end

    // Scoreboard: drain on rvalid first, then record new grants
    always @(negedge clk) begin
        logic [31:0] e;
        if (m0_rvalid) begin
            total++;
            if (exp0_q.size() == 0) begin
                $display("FAIL sb_m0 unexpected rvalid rdata=%h", m0_rdata);
            end else begin
                e = exp0_q.pop_front();
                if (m0_rdata !== e)
                    $display("FAIL sb_m0 rdata got %h want %h", m0_rdata, e);
                else pass++;
            end
        end
        if (m1_rvalid) begin
            total++;
            if (exp1_q.size() == 0) begin
                $display("FAIL sb_m1 unexpected rvalid rdata=%h", m1_rdata);
            end else begin
                e = exp1_q.pop_front();
                if (m1_rdata !== e)
                    $display("FAIL sb_m1 rdata got %h want %h", m1_rdata, e);
                else pass++;
            end
        end
        if (m0_gnt) begin
            if (m0_wr) begin
                ref_mem[m0_addr[9:2]] = m0_wdata;
                ref_wr[m0_addr[9:2]]  = 1'b1;
            end else exp0_q.push_back(ref_val(m0_addr));
        end
        if (m1_gnt) begin
            if (m1_wr) begin
                ref_mem[m1_addr[9:2]] = m1_wdata;
                ref_wr[m1_addr[9:2]]  = 1'b1;
            end else exp1_q.push_back(ref_val(m1_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_wr = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
        p0_req = 0; p1_req = 0;
    endtask

    task automatic test_reset();
        rstn = 0;
        idle();
        step();
        m0_req = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h20;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt, mem_en} !== 3'b000)
            $display("FAIL rst_gnt got %b want 000", {m0_gnt, m1_gnt, mem_en});
        else pass++;
        total++;
        if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 66'h0)
            $display("FAIL rst_rd got %b%b %h %h want 0", m0_rvalid,
                     m1_rvalid, m0_rdata, m1_rdata);
        else pass++;
        step();
        rstn = 1;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt} !== 2'b10)
            $display("FAIL rst_first got %b want 10", {m0_gnt, m1_gnt});
        else pass++;
        step();
        idle();
    endtask

    task automatic test_round_robin();
        m0_req = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({m0_gnt, m1_gnt} !== ((i % 2 == 1) ? 2'b10 : 2'b01))
                $display("FAIL rr_gnt cyc%0d got %b want %b", i,
                         {m0_gnt, m1_gnt}, (i % 2 == 1) ? 2'b10 : 2'b01);
            else pass++;
            total++;
            if (mem_addr !== ((i % 2 == 1) ? 32'h10 : 32'h20))
                $display("FAIL rr_addr cyc%0d got %h", i, mem_addr);
            else pass++;
            step();
        end
        idle();
    endtask

    task automatic test_lock();
        m0_req = 1; m0_addr = 32'h44;
        m1_req = 1; m1_addr = 32'h40; m1_lock = 1;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt} !== 2'b01)
            $display("FAIL lock_c1 got %b want 01", {m0_gnt, m1_gnt});
        else pass++;
        step();
        m1_wr = 1; m1_lock = 0; m1_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt, mem_wr} !== 3'b011)
            $display("FAIL lock_c2 got %b want 011", {m0_gnt, m1_gnt, mem_wr});
        else pass++;
        total++;
        if ({mem_addr, mem_wdata} !== {32'h40, 32'hDEADBEEF})
            $display("FAIL lock_wr got %h/%h want 40/deadbeef",
                     mem_addr, mem_wdata);
        else pass++;
        step();
        m1_req = 0; m1_wr = 0;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt} !== 2'b10)
            $display("FAIL lock_c3 got %b want 10", {m0_gnt, m1_gnt});
        else pass++;
        step();
        m0_addr = 32'h40;
        @(negedge clk);
        step();
        m0_addr = 32'h44; m0_lock = 1;
        @(negedge clk);
        step();
        m0_req = 0; m0_lock = 0;
        m1_req = 1; m1_addr = 32'h20;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt, mem_en} !== 3'b000)
            $display("FAIL lock_hold got %b want 000", {m0_gnt, m1_gnt, mem_en});
        else pass++;
        step();
        m0_req = 1; m0_wr = 1; m0_addr = 32'h48; m0_wdata = 32'h1234_5678;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt} !== 2'b10)
            $display("FAIL lock_rel got %b want 10", {m0_gnt, m1_gnt});
        else pass++;
        step();
        m0_req = 0; m0_wr = 0;
        @(negedge clk);
        total++;
        if (m1_gnt !== 1'b1)
            $display("FAIL lock_after got %b want 1", m1_gnt);
        else pass++;
        step();
        idle();
    endtask

    task automatic test_read_routing();
        m0_req = 1; m0_addr = 32'h8;
        @(negedge clk);
        step();
        m0_req = 0; m0_addr = 0;
        m1_req = 1; m1_addr = 32'hC;
        @(negedge clk);
        total++;
        if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'h11})
            $display("FAIL route_n1 got %b%b %h want 10 00000011",
                     m0_rvalid, m1_rvalid, m0_rdata);
        else pass++;
        step();
        idle();
        @(negedge clk);
        total++;
        if ({m0_rvalid, m1_rvalid, m1_rdata, m0_rdata} !==
            {2'b01, 32'h22, 32'h11})
            $display("FAIL route_n2 got %b%b %h %h want 01 22 11",
                     m0_rvalid, m1_rvalid, m1_rdata, m0_rdata);
        else pass++;
        total++;
        if ({mem_en, mem_addr, mem_wdata} !== 65'h0)
            $display("FAIL idle_bus got %b %h %h want 0",
                     mem_en, mem_addr, mem_wdata);
        else pass++;
        step();
    endtask

    task automatic test_m0_prio();
        p0_req = 1; p1_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({p0_gnt, p1_gnt} !== 2'b10)
                $display("FAIL prio_cyc%0d got %b want 10", i, {p0_gnt, p1_gnt});
            else pass++;
            step();
        end
        p0_req = 0;
        @(negedge clk);
        total++;
        if ({p0_gnt, p1_gnt, p_addr} !== {2'b01, 32'h200})
            $display("FAIL prio_drop got %b %h want 01 200",
                     {p0_gnt, p1_gnt}, p_addr);
        else pass++;
        step();
        idle();
    endtask

    task automatic test_reset_mid_read();
        m0_req = 1; m0_lock = 1; m0_addr = 32'h10;
        @(negedge clk);
        total++;
        if (m0_gnt !== 1'b1)
            $display("FAIL mid_gnt got %b want 1", m0_gnt);
        else pass++;
        step();
        rstn = 0;
        idle();
        exp0_q.delete();
        exp1_q.delete();
        @(negedge clk);
        total++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00)
            $display("FAIL mid_rvalid got %b want 00", {m0_rvalid, m1_rvalid});
        else pass++;
        step();
        rstn = 1;
        m1_req = 1; m1_addr = 32'h20;
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt, m0_rvalid} !== 3'b010)
            $display("FAIL mid_arb got %b want 010", {m0_gnt, m1_gnt, m0_rvalid});
        else pass++;
        step();
        idle();
        @(negedge clk);
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_read_routing();
        test_m0_prio();
        test_reset_mid_read();
        step();
        total++;
        if (exp0_q.size() + exp1_q.size() != 0)
            $display("FAIL sb_drain got %0d/%0d reads outstanding want 0",
                     exp0_q.size(), exp1_q.size());
        else pass++;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
